// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: picks the next fetch address and drives IF/ID and ID/EX
// flush/hold controls, with a non-nesting user/trap/kernel FSM holding EPC and cause.
//
// state      | meaning
// USER_RUN   | normal execution; branches, jumps, stalls, exceptions and interrupts honoured
// TRAP_ENTRY | single cycle after a trap redirect; inputs ignored, fetch vector+4
// KERNEL_RUN | handler running; irq ignored, exc flags double_fault, eret returns to epc
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_ld_use,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc,
  input  logic        eret,
  input  logic        irq,
  input  logic [31:0] id_pc,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        in_kernel,
  output logic        double_fault,
  output logic        hold_pc,
  output logic        hold_if_id,
  output logic        flush_if_id,
  output logic        flush_id_ex
);

  typedef enum logic [1:0] {
    USER_RUN   = 2'd0,
    TRAP_ENTRY = 2'd1,
    KERNEL_RUN = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_EXC  = 2'b01;
  localparam logic [1:0] CAUSE_IRQ  = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic        double_fault_q, double_fault_d;

  // A branch squashes the wrong-path exception in ID, but an interrupt still traps.
  logic exc_valid;
  logic trap_take;

  assign exc_valid = exc && !br_taken;
  assign trap_take = irq || exc_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= USER_RUN;
      pc_q           <= RESET_PC;
      epc_q          <= 32'h0;
      cause_q        <= CAUSE_NONE;
      double_fault_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      epc_q          <= epc_d;
      cause_q        <= cause_d;
      double_fault_q <= double_fault_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q + 32'd4;
    epc_d          = epc_q;
    cause_d        = cause_q;
    double_fault_d = double_fault_q;
    case (state_q)
      USER_RUN: begin
        if (trap_take) begin
          state_d = TRAP_ENTRY;
          pc_d    = TRAP_VECTOR;
          if (exc_valid) begin
            epc_d   = id_pc;
            cause_d = CAUSE_EXC;
          end else begin
            epc_d   = br_taken ? br_target : id_pc;
            cause_d = CAUSE_IRQ;
          end
        end else if (br_taken) begin
          pc_d = br_target;
        end else if (stall_ld_use) begin
          pc_d = pc_q;
        end else if (jump) begin
          pc_d = jump_target;
        end
      end
      TRAP_ENTRY: begin
        state_d = KERNEL_RUN;
      end
      KERNEL_RUN: begin
        if (exc) begin
          double_fault_d = 1'b1;
        end
        if (br_taken) begin
          pc_d = br_target;
        end else if (eret) begin
          pc_d    = epc_q;
          cause_d = CAUSE_NONE;
          state_d = USER_RUN;
        end else if (stall_ld_use) begin
          pc_d = pc_q;
        end else if (jump) begin
          pc_d = jump_target;
        end
      end
      default: begin
        state_d = USER_RUN;
        pc_d    = RESET_PC;
      end
    endcase
  end

  always_comb begin
    hold_pc     = 1'b0;
    hold_if_id  = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!reset) begin
      case (state_q)
        USER_RUN: begin
          if (trap_take || br_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (stall_ld_use) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
          end else if (jump) begin
            flush_if_id = 1'b1;
          end
        end
        KERNEL_RUN: begin
          if (br_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (eret) begin
            flush_if_id = 1'b1;
          end else if (stall_ld_use) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
          end else if (jump) begin
            flush_if_id = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc           = pc_q;
  assign epc          = epc_q;
  assign cause        = cause_q;
  assign double_fault = double_fault_q;
  assign in_kernel    = !reset && (state_q == TRAP_ENTRY || state_q == KERNEL_RUN);

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer and control-flow controller for the five-stage pipeline's fetch stage. Owns the architectural PC register and chooses the next fetch address from reset, trap entry, exception return, EX-stage branch, ID-stage jump, load-use stall or sequential PC+4. Drives the flush/hold controls for the IF/ID and ID/EX pipeline registers. Runs a three-state user/trap/kernel FSM with an exception PC (EPC) and cause register; traps do not nest.

## Interface
- RESET_PC, 32'h00400000, fetch address after reset
- TRAP_VECTOR, 32'h80000004, fetch address on trap entry
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- stall_ld_use  in  1  load-use hazard detected in ID
- br_taken  in  1  branch in EX resolved taken
- br_target  in  32  branch target from EX
- jump  in  1  jump decoded in ID
- jump_target  in  32  jump target from ID
- exc  in  1  illegal instruction in ID
- eret  in  1  exception-return instruction in ID
- irq  in  1  external interrupt request, level
- id_pc  in  32  PC of instruction currently in ID
- pc  out  32  fetch address to IF stage (registered)
- epc  out  32  saved return address (registered)
- cause  out  2  01 = exception, 10 = interrupt, 00 = none (registered)
- in_kernel  out  1  high in TRAP_ENTRY and KERNEL_RUN
- double_fault  out  1  sticky: exc seen in KERNEL_RUN
- hold_pc  out  1  PC not advancing this cycle
- hold_if_id  out  1  IF/ID register must hold
- flush_if_id  out  1  IF/ID register must load a bubble
- flush_id_ex  out  1  ID/EX register must load a bubble

## Operation
- Reset values: pc = RESET_PC, epc = 0, cause = 00, state = USER_RUN, double_fault = 0; combinational outputs forced 0 while reset high.
- USER_RUN next-PC priority (highest first):
  - br_taken: pc <= br_target; flush_if_id = flush_id_ex = 1. Suppresses exc, eret, jump, stall (ID instruction is wrong-path).
  - exc (without br_taken): trap; epc <= id_pc; cause <= 01.
  - irq: trap; epc <= br_taken ? br_target : id_pc; cause <= 10. irq with br_taken traps (not suppressed) and returns to br_target.
  - stall_ld_use: pc holds; hold_pc = hold_if_id = flush_id_ex = 1. Beats jump.
  - jump: pc <= jump_target; flush_if_id = 1.
  - else pc <= pc + 4 (mod 2^32, wraps silently).
- Trap: pc <= TRAP_VECTOR; flush_if_id = flush_id_ex = 1; state <= TRAP_ENTRY.
- eret in USER_RUN: ignored (treated as no-op, pc+4).
- TRAP_ENTRY (exactly one cycle): all inputs ignored; pc <= pc + 4; no flush/hold; state <= KERNEL_RUN.
- KERNEL_RUN: irq ignored; exc sets double_fault (sticky until reset), otherwise ignored. Priority: br_taken > eret > stall_ld_use > jump > pc+4.
  - eret (no br_taken): pc <= epc; flush_if_id = 1; cause <= 00; state <= USER_RUN.
- Targets used as-is; low two bits not masked.
- epc/cause change only on trap entry (cause also cleared on eret).

## Timing
- pc, epc, cause, state, double_fault update on posedge clk; reset clears asynchronously.
- hold/flush outputs combinational from current inputs and state, same cycle as cause.
- Redirect latency: decision in cycle N, new pc visible after edge N+1.
- Trap to first vector fetch: 1 cycle; vector+4 fetched the cycle after (TRAP_ENTRY).
- irq sampled every USER_RUN cycle; a level held through KERNEL_RUN re-traps on the first USER_RUN cycle after eret, after one user instruction is fetched from epc.
- Reset mid-trap returns to USER_RUN at RESET_PC; epc lost.

## Test plan
- Reset, release, 3 idle cycles -> pc sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C; no flush/hold.
- stall_ld_use and jump (target 0x00400100) same cycle at pc 0x00400010 -> pc holds 0x00400010, hold_pc = hold_if_id = flush_id_ex = 1, flush_if_id = 0; next cycle jump alone -> pc 0x00400100.
- br_taken (target 0x00400200) with exc, id_pc 0x00400020 -> pc 0x00400200, both flushes, no trap, cause stays 00.
- irq with br_taken (target 0x00400300) -> pc 0x80000004, epc 0x00400300, cause 10; next pc 0x80000008, in_kernel = 1.
- exc at id_pc 0x00400040 -> trap, epc 0x00400040, cause 01; exc in KERNEL_RUN -> double_fault = 1, no re-trap; eret -> pc 0x00400040, cause 00, USER_RUN.
- Assert reset during TRAP_ENTRY -> pc 0x00400000, epc 0, cause 00, in_kernel 0, double_fault 0 immediately.
